// File: rtl/ping_pkg.sv
// ping_pkg: shared PING protocol states, timing defaults and echo width helper
package ping_pkg;
    typedef enum logic [2:0] {IDLE, TRIG, HOLDOFF, ECHO, DRIVE_LO, RECOVER} state_t;
    localparam int unsigned DEF_TRIG_MIN_CYC = 100;
    localparam int unsigned DEF_TRIG_MAX_CYC = 1000;
    localparam int unsigned DEF_HOLDOFF_CYC  = 37500;
    localparam int unsigned DEF_CYC_PER_CM   = 2900;
    localparam int unsigned DEF_ECHO_MIN_CYC = 5750;
    localparam int unsigned DEF_ECHO_MAX_CYC = 925000;
    localparam int unsigned DEF_RECOVER_CYC  = 10000;
    localparam int DIST_W = 9;
    localparam int CNT_W  = 20;
    localparam int P_W    = 22;
    // Raw product is formed at 22 bits, then clamped into the 20-bit width register
    function automatic logic [CNT_W-1:0] echo_width(input logic [DIST_W-1:0] d, input int unsigned cpc,
                                                    input int unsigned mn, input int unsigned mx);
        logic [P_W-1:0] p;
        p = P_W'(32'(d) * cpc);
        return p < P_W'(mn) ? CNT_W'(mn) : p > P_W'(mx) ? CNT_W'(mx) : p[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/ping_sensor_emulator_if.sv
// ping_sensor_emulator_if: sig pin halves, distance input and status between host side and emulator
//   sig_in/dist_cm host->emulator; sig_out/sig_oe/busy/trig_err emulator->host
interface ping_sensor_emulator_if;
    import ping_pkg::*;
    logic              sig_in;
    logic              sig_out;
    logic              sig_oe;
    logic              busy;
    logic              trig_err;
    logic [DIST_W-1:0] dist_cm;
    modport master(output sig_in, dist_cm, input sig_out, sig_oe, busy, trig_err);
    modport slave(input sig_in, dist_cm, output sig_out, sig_oe, busy, trig_err);
endinterface

// File: rtl/ping_sync.sv
// ping_sync: 2-flop synchronizer for the sig pad with rise/fall detect
//   CLK, reset (async, active-high); sig_in raw pad; rise/fall one-cycle edge flags
module ping_sync (
    input  logic CLK,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);
    logic meta_q, s_q, prev_q;
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            s_q    <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= sig_in;
            s_q    <= meta_q;
            prev_q <= s_q;
        end
    end
    assign rise = s_q & ~prev_q;
    assign fall = ~s_q & prev_q;
endmodule

// File: rtl/ping_sensor_emulator.sv
// ping_sensor_emulator: sensor-side PING model, answers a host trigger with a distance-scaled echo
//   CLK, reset (async, active-high); bus.slave carries sig_in/sig_out/sig_oe, dist_cm, busy, trig_err
module ping_sensor_emulator import ping_pkg::*; #(
    parameter int unsigned TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
    parameter int unsigned TRIG_MAX_CYC = DEF_TRIG_MAX_CYC,
    parameter int unsigned HOLDOFF_CYC  = DEF_HOLDOFF_CYC,
    parameter int unsigned CYC_PER_CM   = DEF_CYC_PER_CM,
    parameter int unsigned ECHO_MIN_CYC = DEF_ECHO_MIN_CYC,
    parameter int unsigned ECHO_MAX_CYC = DEF_ECHO_MAX_CYC,
    parameter int unsigned RECOVER_CYC  = DEF_RECOVER_CYC
) (
    input logic CLK,
    input logic reset,
    ping_sensor_emulator_if.slave bus
);
    localparam logic [CNT_W-1:0] T_MIN = CNT_W'(TRIG_MIN_CYC);
    localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TRIG_MAX_CYC);
    localparam logic [CNT_W-1:0] H_END = CNT_W'(HOLDOFF_CYC);
    localparam logic [CNT_W-1:0] R_END = CNT_W'(RECOVER_CYC);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, w_q, w_d;
    logic             sig_oe_q, sig_oe_d, sig_out_q, sig_out_d;
    logic             busy_q, busy_d, trig_err_q, trig_err_d;
    logic             rise, fall;
    ping_sync u_sync (.CLK(CLK), .reset(reset), .sig_in(bus.sig_in), .rise(rise), .fall(fall));
    // HOLDOFF is entered with cnt=0 and leaves at cnt==HOLDOFF_CYC, giving sig_oe at t0+3+HOLDOFF_CYC
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_d        = w_q;
        trig_err_d = 1'b0;
        case (state_q)
            IDLE: if (rise) begin
                state_d = TRIG;
                cnt_d   = CNT_W'(1);
            end
            TRIG: if (fall) begin
                if (cnt_q >= T_MIN) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                    w_d     = echo_width(bus.dist_cm, CYC_PER_CM, ECHO_MIN_CYC, ECHO_MAX_CYC);
                end else begin
                    state_d    = IDLE;
                    trig_err_d = 1'b1;
                end
            end else if (cnt_q == T_MAX) begin
                state_d    = IDLE;
                trig_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            HOLDOFF: if (cnt_q == H_END) begin
                state_d = ECHO;
                cnt_d   = CNT_W'(1);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ECHO: if (cnt_q == w_q) begin
                state_d = DRIVE_LO;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DRIVE_LO: begin
                state_d = RECOVER;
                cnt_d   = CNT_W'(1);
            end
            RECOVER: if (cnt_q == R_END) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Outputs follow the next state so they line up with the registered state
        sig_oe_d  = state_d == ECHO || state_d == DRIVE_LO;
        sig_out_d = state_d == ECHO;
        busy_d    = state_d != IDLE;
    end
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            w_q        <= '0;
            sig_oe_q   <= 1'b0;
            sig_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            w_q        <= w_d;
            sig_oe_q   <= sig_oe_d;
            sig_out_q  <= sig_out_d;
            busy_q     <= busy_d;
            trig_err_q <= trig_err_d;
        end
    end
    assign bus.sig_oe   = sig_oe_q;
    assign bus.sig_out  = sig_out_q;
    assign bus.busy     = busy_q;
    assign bus.trig_err = trig_err_q;
endmodule
